ssd_capture_decoder: RTL and testbench
======================================

// Module: ssd_capture_decoder
// PURPOSE
// - Receive end of the seven-segment display path: snoops multiplexed segment/anode lines and recovers hex digits.
// - Per-digit stability filter, reverse segment->nibble decode, frame assembly, valid/ready output.
// - Sits beside the display driver on the MIPS board for on-chip self-check of displayed register/PC values.
// PARAMETERS
// - NUM_DIGITS     4   digits per frame (anode lines)
// - STABLE_CYCLES 16   consecutive identical samples required before a digit is captured (>=2)
// - CNT_W          5   stability counter width, must hold STABLE_CYCLES
// PORTS
// - clk        in   1              system clock
// - rst        in   1              asynchronous reset, active-high
// - seg        in   7              segment lines, active-high, bit0=a .. bit6=g
// - an         in   NUM_DIGITS     anode selects, active-low, one low bit = digit index
// - out_ready  in   1              consumer accepts out_value when out_valid=1
// - clear_err  in   1              synchronous clear of sticky flags
// - out_value  out  4*NUM_DIGITS   assembled frame, digit k in bits [4k+3:4k]
// - out_valid  out  1              out_value holds an unaccepted frame
// - frame_bad  out  1              qualifies out_value: >=1 digit had an undecodable pattern
// - bad_seen   out  1              sticky: any undecodable pattern captured
// - overflow   out  1              sticky: frame overwritten while out_valid=1 and out_ready=0
// BEHAVIOUR
// - Reset: all outputs 0; sample regs, counter, digit regs, seen/bad masks cleared; async assert, sync-safe release.
// - Input stage: seg/an registered once (1-cycle latency), no metastability sync (same clock domain as driver).
// - Sample valid only if exactly one an bit is 0; otherwise (blank, multi-select) counter -> 0, no capture.
// - Valid sample equal to previous sample (index+seg): counter++ saturating at STABLE_CYCLES; differs: counter -> 1.
// - Capture on the cycle counter goes STABLE_CYCLES-1 -> STABLE_CYCLES: exactly once per stable run.
// - Decode table (seg hex -> nibble): 3F 0, 06 1, 5B 2, 4F 3, 66 4, 6D 5, 7D 6, 07 7,
//   7F 8, 6F 9, 77 A, 7C B, 58 C, 5E D, 79 E, 71 F; any other pattern = miss.
// - Capture hit: digit_reg[k] <= nibble, bad_mask[k] <= 0. Miss: digit_reg[k] <= 0, bad_mask[k] <= 1, bad_seen <= 1.
// - Capture sets seen[k]; recapture of a seen digit overwrites it (latest value wins).
// - Frame complete when seen becomes all-ones: next cycle out_value <= digits, frame_bad <= |bad_mask,
//   out_valid <= 1; seen and bad_mask cleared same cycle as the load.
// - Handshake: out_valid && out_ready -> out_valid <= 0 next cycle unless a new frame loads.
// - Simultaneous load and accept: new frame loaded, out_valid stays 1, no overflow.
// - Load while out_valid=1 and out_ready=0: frame overwritten, overflow <= 1.
// - out_value/frame_bad stable while out_valid=1 and no load occurs.
// - clear_err clears bad_seen and overflow; a same-cycle set event wins over clear.
// - Reset mid-frame discards partial frame; first frame after reset needs every digit captured anew.
// STRUCTURE
// - Shared package: SEG_* 7-bit pattern constants for 0..F (common with the encoder side), SEG_W=7.
// - Sub-module ssd_to_hex: combinational seg[6:0] -> {hit, nibble[3:0]}; one instance on registered sample.
// - Top: input regs, one-hot check/index encoder, stability counter, digit regfile, frame/handshake regs.
// TESTING
// - Drive an=1110 seg=7'h3F 20 cycles, then 1101/06, 1011/5B, 0111/4F -> one frame out_value=16'h3210,
//   frame_bad=0, out_valid one cycle after last capture.
// - Hold an=1110 seg=7'h3F for 15 cycles only, then blank -> no capture, seen stays 0.
// - Digit 0 pattern 7'h7F (8) stable, others A/B/C -> out_value=16'hCBA8; repeat with digit 2 = 7'h01
//   -> out_value=16'hC0A8, frame_bad=1, bad_seen=1 until clear_err.
// - out_ready=0, two complete frames 16'h1234 then 16'h5678 -> out_value=16'h5678, overflow=1; out_ready=1 -> out_valid drops.
// - an=1100 (two selects) with stable seg for 40 cycles -> no capture; rst pulse mid-frame -> all outputs 0, seen cleared.

Source files
------------

// File: rtl/ssd_capture_decoder_pkg.sv
// Shared seven-segment definitions for the display encoder and the
// capture decoder: segment width, 0..F glyph patterns, decode result.
package ssd_capture_decoder_pkg;

  localparam int SEG_W = 7;

  // bit0=a .. bit6=g, active-high
  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h58;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  typedef struct packed {
    logic       hit;
    logic [3:0] nib;
  } hex_t;

endpackage

// File: rtl/ssd_capture_decoder_to_hex.sv
// Reverse glyph decode: segment pattern -> hex nibble plus a hit flag.
// Any pattern outside the sixteen glyphs reports a miss with nibble 0.
module ssd_to_hex
  import ssd_capture_decoder_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output hex_t             hex
);

  // table lookup; unknown glyphs fall through to a miss
  always_comb begin
    hex = '{hit: 1'b1, nib: 4'h0};
    case (seg)
      SEG_0:   hex.nib = 4'h0;
      SEG_1:   hex.nib = 4'h1;
      SEG_2:   hex.nib = 4'h2;
      SEG_3:   hex.nib = 4'h3;
      SEG_4:   hex.nib = 4'h4;
      SEG_5:   hex.nib = 4'h5;
      SEG_6:   hex.nib = 4'h6;
      SEG_7:   hex.nib = 4'h7;
      SEG_8:   hex.nib = 4'h8;
      SEG_9:   hex.nib = 4'h9;
      SEG_A:   hex.nib = 4'hA;
      SEG_B:   hex.nib = 4'hB;
      SEG_C:   hex.nib = 4'hC;
      SEG_D:   hex.nib = 4'hD;
      SEG_E:   hex.nib = 4'hE;
      SEG_F:   hex.nib = 4'hF;
      default: hex.hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ssd_capture_decoder.sv
// Snoops multiplexed segment/anode lines, filters each digit for
// stability, decodes glyphs and hands out whole frames via valid/ready.
module ssd_capture_decoder
  import ssd_capture_decoder_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEG_W-1:0]        seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    out_ready,
  input  logic                    clear_err,
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic                    out_valid,
  output logic                    frame_bad,
  output logic                    bad_seen,
  output logic                    overflow
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0]           seg_q;
  logic [SEG_W-1:0]           prev_seg;
  logic [NUM_DIGITS-1:0]      an_q;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           prev_idx;
  logic                       sel_one;
  logic                       sel_many;
  logic                       valid_smp;
  logic                       same;
  logic                       capture;
  logic [CNT_W-1:0]           cnt;
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS-1:0]      seen;
  logic [NUM_DIGITS-1:0]      bad_mask;
  logic [NUM_DIGITS-1:0]      cap_mask;
  logic [NUM_DIGITS-1:0]      seen_base;
  logic [NUM_DIGITS-1:0]      bad_base;
  logic                       frame_full;
  hex_t                       hex;

  ssd_to_hex u_dec (
    .seg (seg_q),
    .hex (hex)
  );

  // single input register; driver shares our clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= '0;
      an_q  <= '0;
    end else begin
      seg_q <= seg;
      an_q  <= an;
    end
  end

  // find the one active-low anode; flag blank or multi-select
  always_comb begin
    sel_one  = 1'b0;
    sel_many = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        if (sel_one) sel_many = 1'b1;
        sel_one = 1'b1;
        idx     = IDX_W'(i);
      end
    end
  end

  assign valid_smp  = sel_one && !sel_many;
  assign same       = (idx == prev_idx) && (seg_q == prev_seg);
  assign capture    = valid_smp && same && (cnt == CNT_ARM);
  assign cap_mask   = capture ? (NUM_DIGITS'(1) << idx) : '0;
  assign frame_full = &seen;
  assign seen_base  = frame_full ? '0 : seen;
  assign bad_base   = frame_full ? '0 : bad_mask;

  // run-length filter over consecutive identical samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      prev_idx <= '0;
      prev_seg <= '0;
    end else if (!valid_smp) begin
      cnt <= '0;
    end else begin
      prev_idx <= idx;
      prev_seg <= seg_q;
      if (!same)               cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end
  end

  // digit regfile with seen/bad tracking; frame load empties the masks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits   <= '0;
      seen     <= '0;
      bad_mask <= '0;
    end else begin
      if (capture) digits[idx] <= hex.hit ? hex.nib : 4'h0;
      seen     <= seen_base | cap_mask;
      bad_mask <= (bad_base & ~cap_mask) | (hex.hit ? '0 : cap_mask);
    end
  end

  // frame output, handshake and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_value <= '0;
      out_valid <= 1'b0;
      frame_bad <= 1'b0;
      bad_seen  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (frame_full) begin
        out_value <= digits;
        frame_bad <= |bad_mask;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (frame_full && out_valid && !out_ready) overflow <= 1'b1;
      else if (clear_err)                        overflow <= 1'b0;
      if (capture && !hex.hit) bad_seen <= 1'b1;
      else if (clear_err)      bad_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ssd_capture_decoder.sv
// Bench for ssd_capture_decoder: directed frame table, corner sequences,
// and random segment streams checked against a run-length model.
module tb_ssd_capture_decoder;

  localparam int STABLE = 16;

  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        out_ready;
  logic        clear_err;
  logic [15:0] out_value;
  logic        out_valid;
  logic        frame_bad;
  logic        bad_seen;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  ssd_capture_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .an        (an),
    .out_ready (out_ready),
    .clear_err (clear_err),
    .out_value (out_value),
    .out_valid (out_valid),
    .frame_bad (frame_bad),
    .bad_seen  (bad_seen),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic [3:0]  m_last_an;
  logic [6:0]  m_last_seg;
  int          m_run;
  logic [3:0]  m_dig [4];
  bit          m_seen [4];
  bit          m_bad [4];
  logic [15:0] m_val;
  bit          m_valid;
  bit          m_fbad;
  bit          m_bseen;
  bit          m_ovf;

  function automatic int glyph(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (PAT[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [3:0] sel(input int d);
    logic [3:0] m;
    m = 4'hF;
    m[d] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    m_an = '0; m_seg = '0; m_last_an = '0; m_last_seg = '0; m_run = 0;
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = '0; m_seen[i] = 0; m_bad[i] = 0;
    end
    m_val = '0; m_valid = 0; m_fbad = 0; m_bseen = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit full, anyb, cap, set_ovf;
    logic [15:0] frame;
    int zeros, k, g;
    full = 1; anyb = 0; frame = '0;
    for (int i = 0; i < 4; i++) begin
      full &= m_seen[i];
      anyb |= m_bad[i];
      frame[4*i +: 4] = m_dig[i];
    end
    zeros = 0; k = 0; cap = 0;
    for (int i = 0; i < 4; i++) if (!m_an[i]) begin zeros++; k = i; end
    if (zeros == 1) begin
      if (m_run > 0 && m_an == m_last_an && m_seg == m_last_seg) m_run++;
      else m_run = 1;
      m_last_an = m_an; m_last_seg = m_seg;
      cap = (m_run == STABLE);
    end else begin
      m_run = 0;
    end
    set_ovf = full && m_valid && !out_ready;
    if (full) begin
      m_val = frame; m_fbad = anyb; m_valid = 1;
      for (int i = 0; i < 4; i++) begin m_seen[i] = 0; m_bad[i] = 0; end
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (set_ovf) m_ovf = 1; else if (clear_err) m_ovf = 0;
    if (cap) begin
      g = glyph(m_seg);
      m_seen[k] = 1;
      m_dig[k] = (g < 0) ? 4'h0 : 4'(g);
      m_bad[k] = (g < 0);
    end
    if (cap && g < 0) m_bseen = 1; else if (clear_err) m_bseen = 0;
    m_an = an; m_seg = seg;
  endtask

  task automatic cycle();
    logic [19:0] got, exp;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    got = {out_value, out_valid, frame_bad, bad_seen, overflow};
    exp = {m_val, m_valid, m_fbad, m_bseen, m_ovf};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL model t=%0t got %h want %h", $time, got, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a; seg = s;
    repeat (n) cycle();
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, " value"}, out_value, 16'h0);
    chk({name, " valid"}, 16'(out_valid), 16'h0);
    chk({name, " fbad"}, 16'(frame_bad), 16'h0);
    chk({name, " bseen"}, 16'(bad_seen), 16'h0);
    chk({name, " ovf"}, 16'(overflow), 16'h0);
  endtask

  typedef struct {
    logic [3:0][6:0] pats;
    logic [15:0]     val;
    bit              fbad;
    bit              bseen;
    bit              ovf;
    bit              acc;
  } row_t;

  row_t rows [5];

  initial begin
    rows[0] = '{pats: {7'h4F, 7'h5B, 7'h06, 7'h3F}, val: 16'h3210,
                fbad: 0, bseen: 0, ovf: 0, acc: 1};
    rows[1] = '{pats: {7'h58, 7'h7C, 7'h77, 7'h7F}, val: 16'hCBA8,
                fbad: 0, bseen: 0, ovf: 0, acc: 1};
    rows[2] = '{pats: {7'h58, 7'h01, 7'h77, 7'h7F}, val: 16'hC0A8,
                fbad: 1, bseen: 1, ovf: 0, acc: 1};
    rows[3] = '{pats: {7'h06, 7'h5B, 7'h4F, 7'h66}, val: 16'h1234,
                fbad: 0, bseen: 0, ovf: 0, acc: 0};
    rows[4] = '{pats: {7'h6D, 7'h7D, 7'h07, 7'h7F}, val: 16'h5678,
                fbad: 0, bseen: 0, ovf: 1, acc: 1};

    rst = 1'b1; an = 4'hF; seg = '0; out_ready = 1'b0; clear_err = 1'b0;
    model_reset();
    repeat (2) cycle();
    chk_idle("reset");
    rst = 1'b0;
    hold(4'hF, 7'h00, 2);

    for (int r = 0; r < 5; r++) begin
      for (int d = 0; d < 4; d++) hold(sel(d), rows[r].pats[d], 20);
      hold(4'hF, 7'h00, 1);
      chk("row valid", 16'(out_valid), 16'h1);
      chk("row value", out_value, rows[r].val);
      chk("row fbad", 16'(frame_bad), 16'(rows[r].fbad));
      chk("row bseen", 16'(bad_seen), 16'(rows[r].bseen));
      chk("row ovf", 16'(overflow), 16'(rows[r].ovf));
      if (rows[r].acc) begin
        out_ready = 1'b1;
        hold(4'hF, 7'h00, 1);
        out_ready = 1'b0;
        chk("row accept", 16'(out_valid), 16'h0);
        chk("row hold value", out_value, rows[r].val);
      end
      if (r == 2 || r == 4) begin
        clear_err = 1'b1;
        hold(4'hF, 7'h00, 1);
        clear_err = 1'b0;
        chk("clear bseen", 16'(bad_seen), 16'h0);
        chk("clear ovf", 16'(overflow), 16'h0);
      end
    end

    // one cycle short of stable: digit 0 must not count
    hold(sel(0), 7'h3F, 15);
    hold(4'hF, 7'h00, 3);
    hold(sel(1), 7'h06, 20);
    hold(sel(2), 7'h5B, 20);
    hold(sel(3), 7'h4F, 20);
    hold(4'hF, 7'h00, 2);
    chk("short run", 16'(out_valid), 16'h0);
    hold(sel(0), 7'h3F, 20);
    hold(4'hF, 7'h00, 2);
    chk("late d0 valid", 16'(out_valid), 16'h1);
    chk("late d0 value", out_value, 16'h3210);
    out_ready = 1'b1;
    hold(4'hF, 7'h00, 1);
    out_ready = 1'b0;

    // multi-select never captures; reset drops the partial frame
    hold(4'b1100, 7'h3F, 40);
    hold(sel(1), 7'h06, 20);
    hold(sel(2), 7'h5B, 20);
    hold(sel(3), 7'h4F, 20);
    hold(4'hF, 7'h00, 2);
    chk("multi sel", 16'(out_valid), 16'h0);
    rst = 1'b1;
    hold(4'hF, 7'h00, 1);
    chk_idle("mid rst");
    rst = 1'b0;
    hold(sel(0), 7'h3F, 20);
    hold(4'hF, 7'h00, 2);
    chk("post rst", 16'(out_valid), 16'h0);
    hold(sel(1), 7'h06, 20);
    hold(sel(2), 7'h5B, 20);
    hold(sel(3), 7'h4F, 20);
    hold(4'hF, 7'h00, 2);
    chk("post rst valid", 16'(out_valid), 16'h1);
    chk("post rst value", out_value, 16'h3210);

    // random segment streams against the model
    for (int s = 0; s < 300; s++) begin
      int r, n;
      logic [3:0] a;
      logic [6:0] sg;
      r = int'($urandom_range(0, 9));
      if (r < 8)       a = sel(int'($urandom_range(0, 3)));
      else if (r == 8) a = 4'hF;
      else             a = 4'($urandom);
      if ($urandom_range(0, 3) != 0) sg = PAT[$urandom_range(0, 15)];
      else                           sg = 7'($urandom);
      n = int'($urandom_range(1, 40));
      rst = ($urandom_range(0, 99) == 0);
      an = a; seg = sg;
      for (int c = 0; c < n; c++) begin
        out_ready = ($urandom_range(0, 3) == 0);
        clear_err = ($urandom_range(0, 19) == 0);
        cycle();
        rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
